// File: rtl/uc_pkg.sv
// Shared types for the multicycle RV32I control unit: opcodes, FSM states, ALU commands, mux selects.
// Optional memory handshake ports are enabled with UC_MEM_WAIT_EN (see uc_multicycle_if).
package uc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EX_R     = 4'd2,
    EX_I     = 4'd3,
    EX_LUI   = 4'd4,
    EX_AUIPC = 4'd5,
    EX_JAL   = 4'd6,
    EX_JALR  = 4'd7,
    EX_BR    = 4'd8,
    EX_ST    = 4'd9,
    LD_ADDR  = 4'd10,
    LD_MEM   = 4'd11,
    LD_WB    = 4'd12,
    TRAP     = 4'd13
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_cmd_e;

  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_BRANCH  = 2'd1;
  localparam logic [1:0] PC_ALU     = 2'd2;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RF_ALU     = 2'd0;
  localparam logic [1:0] RF_MEM     = 2'd1;
  localparam logic [1:0] RF_PC      = 2'd2;

  // br marks the branch state; its pc_we is resolved later from live ALU flags.
  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic       br;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_cmd_e   alu_cmd;
    logic       rf_we;
    logic [1:0] rf_src;
    logic       d_mem_we;
    logic       d_mem_re;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(input state_e s, input alu_cmd_e dec_cmd);
    ctrl_t c;
    c = '0;
    c.alu_cmd = ALU_ADD;
    case (s)
      FETCH: begin
        c.ir_we  = 1'b1;
        c.pc_we  = 1'b1;
        c.pc_src = PC_PLUS4;
      end
      EX_R: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_cmd   = dec_cmd;
        c.rf_we     = 1'b1;
        c.rf_src    = RF_ALU;
      end
      EX_I: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_cmd   = dec_cmd;
        c.rf_we     = 1'b1;
        c.rf_src    = RF_ALU;
      end
      EX_LUI: begin
        c.alu_src_a = SRC_A_ZERO;
        c.alu_src_b = SRC_B_IMM;
        c.rf_we     = 1'b1;
      end
      EX_AUIPC: begin
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_IMM;
        c.rf_we     = 1'b1;
      end
      EX_JAL: begin
        c.rf_we  = 1'b1;
        c.rf_src = RF_PC;
        c.pc_we  = 1'b1;
        c.pc_src = PC_BRANCH;
      end
      EX_JALR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.rf_we     = 1'b1;
        c.rf_src    = RF_PC;
        c.pc_we     = 1'b1;
        c.pc_src    = PC_ALU;
      end
      EX_BR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_cmd   = ALU_SUB;
        c.br        = 1'b1;
        c.pc_src    = PC_BRANCH;
      end
      EX_ST: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.d_mem_we  = 1'b1;
      end
      LD_ADDR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
      end
      LD_MEM: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.d_mem_re  = 1'b1;
      end
      LD_WB: begin
        c.rf_we  = 1'b1;
        c.rf_src = RF_MEM;
      end
      TRAP:    c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uc_multicycle_if.sv
// IR-field inputs and datapath control outputs of the multicycle control unit.
// UC_MEM_WAIT_EN adds the i_mem_ready / d_mem_ready handshake inputs.
interface uc_multicycle_if #(parameter int NUM_FLAGS = 4);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 funct7_b5;
  logic [NUM_FLAGS-1:0] alu_flags;
`ifdef UC_MEM_WAIT_EN
  logic                 i_mem_ready;
  logic                 d_mem_ready;
`endif
  logic                 ir_we;
  logic                 pc_we;
  logic [1:0]           pc_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [3:0]           alu_cmd;
  logic                 rf_we;
  logic [1:0]           rf_src;
  logic                 d_mem_we;
  logic                 d_mem_re;
  logic                 illegal;

  // Memory ready: a request held high completes in the cycle ready is seen high.
  modport master (
`ifdef UC_MEM_WAIT_EN
    input  i_mem_ready, d_mem_ready,
`endif
    input  opcode, funct3, funct7_b5, alu_flags,
    output ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_cmd,
    output rf_we, rf_src, d_mem_we, d_mem_re, illegal
  );

  modport slave (
`ifdef UC_MEM_WAIT_EN
    output i_mem_ready, d_mem_ready,
`endif
    output opcode, funct3, funct7_b5, alu_flags,
    input  ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_cmd,
    input  rf_we, rf_src, d_mem_we, d_mem_re, illegal
  );

endinterface

// File: rtl/uc_alu_dec.sv
// ALU command decode from funct3/funct7_b5 for OP and OP-IMM instructions.
// Flags funct7_b5 combinations that are not valid RV32I encodings.
module uc_alu_dec
  import uc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       is_rtype,
  output alu_cmd_e   alu_cmd,
  output logic       illegal_funct
);

  // For OP-IMM, bit 30 is immediate data except on the shifts.
  logic strict_b5;
  assign strict_b5 = is_rtype & funct7_b5;

  always_comb begin
    alu_cmd       = ALU_ADD;
    illegal_funct = 1'b0;
    case (funct3)
      3'b000: if (strict_b5) alu_cmd = ALU_SUB;
      3'b001: begin
        alu_cmd       = ALU_SLL;
        illegal_funct = funct7_b5;
      end
      3'b010: begin
        alu_cmd       = ALU_SLT;
        illegal_funct = strict_b5;
      end
      3'b011: begin
        alu_cmd       = ALU_SLTU;
        illegal_funct = strict_b5;
      end
      3'b100: begin
        alu_cmd       = ALU_XOR;
        illegal_funct = strict_b5;
      end
      3'b101: alu_cmd = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110: begin
        alu_cmd       = ALU_OR;
        illegal_funct = strict_b5;
      end
      3'b111: begin
        alu_cmd       = ALU_AND;
        illegal_funct = strict_b5;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uc_multicycle.sv
// Multicycle RV32I control unit: Moore FSM with registered control word, branch pc_we from live flags.
// UC_MEM_WAIT_EN: FETCH, EX_ST and LD_MEM stall on i_mem_ready / d_mem_ready.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int NUM_FLAGS       = 4,
  parameter int FLAG_ZERO       = 0,
  parameter int FLAG_MSB        = 1,
  parameter int FLAG_OVF        = 2,
  parameter int FLAG_CARRY      = 3,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  uc_multicycle_if.master   bus,
  output state_e            state
);

  state_e               state_q;
  state_e               state_nxt;
  ctrl_t                ctrl_q;
  alu_cmd_e             dec_cmd;
  logic                 dec_ill;
  logic                 is_rtype;
  logic                 instr_ill;
  logic                 imem_ok;
  logic                 dmem_ok;
  logic                 br_taken;
  logic                 lt;
  logic [NUM_FLAGS-1:0] flags;

`ifdef UC_MEM_WAIT_EN
  assign imem_ok = bus.i_mem_ready;
  assign dmem_ok = bus.d_mem_ready;
`else
  assign imem_ok = 1'b1;
  assign dmem_ok = 1'b1;
`endif

  assign is_rtype = (bus.opcode == OPC_OP);
  assign flags    = bus.alu_flags;

  uc_alu_dec u_alu_dec (
    .funct3        (bus.funct3),
    .funct7_b5     (bus.funct7_b5),
    .is_rtype      (is_rtype),
    .alu_cmd       (dec_cmd),
    .illegal_funct (dec_ill)
  );

  always_comb begin
    instr_ill = 1'b0;
    case (bus.opcode)
      OPC_OP, OPC_OP_IMM: instr_ill = dec_ill;
      OPC_JALR:           instr_ill = (bus.funct3 != 3'b000);
      OPC_BRANCH:         instr_ill = (bus.funct3 == 3'b010) || (bus.funct3 == 3'b011);
      OPC_LOAD:           instr_ill = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
      OPC_STORE:          instr_ill = (bus.funct3 > 3'b010);
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_SYSTEM: instr_ill = 1'b0;
      default:            instr_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      FETCH: if (imem_ok) state_nxt = DECODE;
      DECODE: begin
        if (instr_ill) begin
          if (TRAP_ON_ILLEGAL) state_nxt = TRAP;
          else                 state_nxt = FETCH;
        end else begin
          case (bus.opcode)
            OPC_OP:     state_nxt = EX_R;
            OPC_OP_IMM: state_nxt = EX_I;
            OPC_LUI:    state_nxt = EX_LUI;
            OPC_AUIPC:  state_nxt = EX_AUIPC;
            OPC_JAL:    state_nxt = EX_JAL;
            OPC_JALR:   state_nxt = EX_JALR;
            OPC_BRANCH: state_nxt = EX_BR;
            OPC_STORE:  state_nxt = EX_ST;
            OPC_LOAD:   state_nxt = LD_ADDR;
            default:    state_nxt = FETCH;
          endcase
        end
      end
      EX_ST:   if (dmem_ok) state_nxt = FETCH;
      LD_ADDR: state_nxt = LD_MEM;
      LD_MEM:  if (dmem_ok) state_nxt = LD_WB;
      LD_WB:   state_nxt = FETCH;
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  // Control word is computed for the state being entered, so it is valid from the first cycle there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_for(FETCH, ALU_ADD);
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= ctrl_for(state_nxt, dec_cmd);
    end
  end

  assign lt = flags[FLAG_MSB] ^ flags[FLAG_OVF];

  always_comb begin
    case (bus.funct3)
      3'b000:  br_taken = flags[FLAG_ZERO];
      3'b001:  br_taken = ~flags[FLAG_ZERO];
      3'b100:  br_taken = lt;
      3'b101:  br_taken = ~lt;
      3'b110:  br_taken = ~flags[FLAG_CARRY];
      3'b111:  br_taken = flags[FLAG_CARRY];
      default: br_taken = 1'b0;
    endcase
  end

  // Every output is forced to zero (alu_cmd = ADD) while reset is held.
  assign bus.ir_we     = rst_n & ctrl_q.ir_we & imem_ok;
  assign bus.pc_we     = rst_n & ((ctrl_q.pc_we & ((state_q != FETCH) | imem_ok))
                                  | (ctrl_q.br & br_taken));
  assign bus.pc_src    = rst_n ? ctrl_q.pc_src    : 2'd0;
  assign bus.alu_src_a = rst_n ? ctrl_q.alu_src_a : 2'd0;
  assign bus.alu_src_b = rst_n ? ctrl_q.alu_src_b : 2'd0;
  assign bus.alu_cmd   = rst_n ? ctrl_q.alu_cmd   : ALU_ADD;
  assign bus.rf_we     = rst_n & ctrl_q.rf_we;
  assign bus.rf_src    = rst_n ? ctrl_q.rf_src    : 2'd0;
  assign bus.d_mem_we  = rst_n & ctrl_q.d_mem_we;
  assign bus.d_mem_re  = rst_n & ctrl_q.d_mem_re;
  assign bus.illegal   = rst_n & (ctrl_q.illegal
                                  | (!TRAP_ON_ILLEGAL && (state_q == DECODE) && instr_ill));

  assign state = state_q;

endmodule

// File: tb/tb_uc_multicycle.sv
// Directed bench for uc_multicycle: checks control words and state sequence per instruction class.
// With UC_MEM_WAIT_EN defined it also exercises the memory stall handshake.
module tb_uc_multicycle;
  import uc_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e state;
  int     n_chk;
  int     n_fail;
  logic [17:0] exp_q[$];
  state_e      st_q[$];
  logic [17:0] obs_ctl;

  uc_multicycle_if #(.NUM_FLAGS(4)) bus ();

  uc_multicycle dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  assign obs_ctl = {bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_cmd,
                    bus.rf_we, bus.rf_src, bus.d_mem_we, bus.d_mem_re, bus.illegal};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "timeout");
  end

  function automatic logic [17:0] ctl(input logic ir, input logic pc, input logic [1:0] pcs,
                                      input logic [1:0] a, input logic [1:0] b, input logic [3:0] cmd,
                                      input logic rf, input logic [1:0] rfs, input logic dw,
                                      input logic dr, input logic ill);
    return {ir, pc, pcs, a, b, cmd, rf, rfs, dw, dr, ill};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_e exp);
    chk(tag, 32'(state), 32'(exp));
  endtask

  task automatic chk_ctl(input string tag, input logic [17:0] exp);
    chk(tag, 32'(obs_ctl), 32'(exp));
  endtask

  // Called in FETCH: load IR fields, check FETCH, advance into DECODE.
  task automatic issue(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic b5, input bit chk_dec);
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.funct7_b5 = b5;
    #1;
    chk_st({tag, "_fetch"}, FETCH);
    chk_ctl({tag, "_fetch_ctl"}, ctl(1, 1, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0));
    tick();
    chk_st({tag, "_decode"}, DECODE);
    if (chk_dec) chk_ctl({tag, "_decode_ctl"}, 18'd0);
  endtask

  // Single execute cycle then back to FETCH.
  task automatic ex1(input string tag, input state_e st, input logic [17:0] c);
    tick();
    chk_st({tag, "_ex"}, st);
    chk_ctl({tag, "_ex_ctl"}, c);
    tick();
    chk_st({tag, "_done"}, FETCH);
  endtask

  task automatic branch(input string tag, input logic [2:0] f3, input logic [3:0] flags,
                        input logic taken);
    bus.alu_flags = flags;
    issue(tag, OPC_BRANCH, f3, 1'b0, 1'b1);
    ex1(tag, EX_BR, ctl(0, taken, 1, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
  endtask

  // scoreboard + directed sequence
  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.opcode    = 7'd0;
    bus.funct3    = 3'd0;
    bus.funct7_b5 = 1'b0;
    bus.alu_flags = 4'd0;
`ifdef UC_MEM_WAIT_EN
    bus.i_mem_ready = 1'b1;
    bus.d_mem_ready = 1'b1;
`endif
    tick();
    tick();
    chk_ctl("reset_ctl", 18'd0);
    chk_st("reset_state", FETCH);
    rst_n = 1'b1;

    issue("sub", OPC_OP, 3'b000, 1'b1, 1'b1);
    ex1("sub", EX_R, ctl(0, 0, 0, 0, 0, ALU_SUB, 1, 0, 0, 0, 0));
    issue("sra", OPC_OP, 3'b101, 1'b1, 1'b1);
    ex1("sra", EX_R, ctl(0, 0, 0, 0, 0, ALU_SRA, 1, 0, 0, 0, 0));
    issue("and", OPC_OP, 3'b111, 1'b0, 1'b1);
    ex1("and", EX_R, ctl(0, 0, 0, 0, 0, ALU_AND, 1, 0, 0, 0, 0));
    issue("addi_b5", OPC_OP_IMM, 3'b000, 1'b1, 1'b1);
    ex1("addi_b5", EX_I, ctl(0, 0, 0, 0, 1, ALU_ADD, 1, 0, 0, 0, 0));
    issue("srai", OPC_OP_IMM, 3'b101, 1'b1, 1'b1);
    ex1("srai", EX_I, ctl(0, 0, 0, 0, 1, ALU_SRA, 1, 0, 0, 0, 0));
    issue("sltiu", OPC_OP_IMM, 3'b011, 1'b0, 1'b1);
    ex1("sltiu", EX_I, ctl(0, 0, 0, 0, 1, ALU_SLTU, 1, 0, 0, 0, 0));
    issue("lui", OPC_LUI, 3'b000, 1'b0, 1'b1);
    ex1("lui", EX_LUI, ctl(0, 0, 0, 2, 1, ALU_ADD, 1, 0, 0, 0, 0));
    issue("auipc", OPC_AUIPC, 3'b000, 1'b0, 1'b1);
    ex1("auipc", EX_AUIPC, ctl(0, 0, 0, 1, 1, ALU_ADD, 1, 0, 0, 0, 0));
    issue("jal", OPC_JAL, 3'b000, 1'b0, 1'b1);
    ex1("jal", EX_JAL, ctl(0, 1, 1, 0, 0, ALU_ADD, 1, 2, 0, 0, 0));
    issue("jalr", OPC_JALR, 3'b000, 1'b0, 1'b1);
    ex1("jalr", EX_JALR, ctl(0, 1, 2, 0, 1, ALU_ADD, 1, 2, 0, 0, 0));
    issue("sw", OPC_STORE, 3'b010, 1'b0, 1'b1);
    ex1("sw", EX_ST, ctl(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 1, 0, 0));

    // Load: five-cycle sequence checked against the expected queues.
    issue("lw", OPC_LOAD, 3'b010, 1'b0, 1'b1);
    st_q.push_back(LD_ADDR); exp_q.push_back(ctl(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 0, 0));
    st_q.push_back(LD_MEM);  exp_q.push_back(ctl(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 1, 0));
    st_q.push_back(LD_WB);   exp_q.push_back(ctl(0, 0, 0, 0, 0, ALU_ADD, 1, 1, 0, 0, 0));
    st_q.push_back(FETCH);   exp_q.push_back(ctl(1, 1, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      tick();
      chk_st("lw_seq_state", st_q.pop_front());
      chk_ctl("lw_seq_ctl", exp_q.pop_front());
    end

    // BLT: MSB^OVF decides, flags changed inside the same EX_BR cycle.
    bus.alu_flags = 4'b0010;
    issue("blt", OPC_BRANCH, 3'b100, 1'b0, 1'b1);
    tick();
    chk_st("blt_ex", EX_BR);
    chk_ctl("blt_taken", ctl(0, 1, 1, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
    bus.alu_flags = 4'b0110;
    #1;
    chk_ctl("blt_not_taken", ctl(0, 0, 1, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
    tick();
    chk_st("blt_done", FETCH);

    branch("beq_z", 3'b000, 4'b0001, 1'b1);
    branch("bne_z", 3'b001, 4'b0001, 1'b0);
    branch("bge_lt", 3'b101, 4'b0010, 1'b0);
    branch("bltu_borrow", 3'b110, 4'b0000, 1'b1);
    branch("bgeu_borrow", 3'b111, 4'b0000, 1'b0);
    branch("bgeu_carry", 3'b111, 4'b1000, 1'b1);

    issue("fence", OPC_FENCE, 3'b000, 1'b0, 1'b1);
    chk("fence_legal", 32'(bus.illegal), 32'd0);
    tick();

    // Reset held two cycles in LD_MEM.
    issue("rst_ld", OPC_LOAD, 3'b000, 1'b0, 1'b1);
    tick();
    tick();
    chk_st("rst_ld_mem", LD_MEM);
    rst_n = 1'b0;
    #1;
    chk_ctl("rst_ld_forced0", 18'd0);
    tick();
    chk_ctl("rst_ld_hold1", 18'd0);
    tick();
    chk_ctl("rst_ld_hold2", 18'd0);
    rst_n = 1'b1;
    bus.opcode = OPC_LUI;
    #1;
    chk_st("rst_ld_restart", FETCH);
    chk_ctl("rst_ld_no_rf_we", ctl(1, 1, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0));

    // Illegal opcode traps and stays there.
    issue("ill_op", 7'b1111111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_st("ill_op_trap", TRAP);
      chk_ctl("ill_op_ctl", ctl(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 1));
    end
    rst_n = 1'b0;
    tick();
    chk_ctl("ill_op_reset", 18'd0);
    rst_n = 1'b1;

    issue("ill_br", OPC_BRANCH, 3'b010, 1'b0, 1'b0);
    tick();
    chk_st("ill_br_trap", TRAP);
    chk("ill_br_flag", 32'(bus.illegal), 32'd1);
    issue_reset_after: begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    issue("ill_r", OPC_OP, 3'b100, 1'b1, 1'b0);
    tick();
    chk_st("ill_r_trap", TRAP);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

`ifdef UC_MEM_WAIT_EN
    bus.d_mem_ready = 1'b0;
    issue("sw_wait", OPC_STORE, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_st("sw_wait_state", EX_ST);
      chk_ctl("sw_wait_ctl", ctl(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 1, 0, 0));
    end
    bus.d_mem_ready = 1'b1;
    tick();
    chk_st("sw_wait_done", FETCH);
    bus.i_mem_ready = 1'b0;
    #1;
    chk_ctl("fetch_stall_ctl", 18'd0);
    tick();
    chk_st("fetch_stall_state", FETCH);
    bus.i_mem_ready = 1'b1;
    #1;
    chk_ctl("fetch_ready_ctl", ctl(1, 1, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
